xgs_trig_activation: RTL and testbench

Grab-trigger qualification stage sitting directly upstream of the XGS grab controller. It selects the grab source (immediate, hardware, software, SFNC) and synchronizes and glitch-filters the external hardware trigger. It applies the activation mode (rising, falling, any edge, level high, level low) and presents one trigger request at a time to the grab controller with a req/ack handshake. Triggers that arrive while a request is pending are reported as overruns and counted.

---
 rtl/xgs_trig_activation.sv | 165 ++++++++++++++++
 tb/tb_xgs_trig_activation.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgs_trig_activation.sv
// Grab-trigger qualification: source select, HW trigger sync/glitch filter,
// activation-mode decode and a single-outstanding req/ack request with overrun counting.
module xgs_trig_activation #(
    parameter int unsigned FILTER_W = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                sys_clk,
    input  logic                sys_reset,
    input  logic                grab_en,
    input  logic [2:0]          grab_src,
    input  logic [2:0]          trig_act,
    input  logic [FILTER_W-1:0] filter_len,
    input  logic                hw_trig_in,
    input  logic                sw_trig,
    input  logic                sfnc_trig,
    input  logic                trig_ack,
    input  logic                cnt_clr,
    output logic                trig_req,
    output logic                trig_overrun,
    output logic [CNT_W-1:0]    trig_missed_cnt,
    output logic                hw_trig_filt
);

    localparam logic [2:0] SRC_IMMEDIATE = 3'd1;
    localparam logic [2:0] SRC_HW        = 3'd2;
    localparam logic [2:0] SRC_SW        = 3'd3;
    localparam logic [2:0] SRC_SFNC      = 3'd4;

    localparam logic [2:0] ACT_RISING   = 3'd0;
    localparam logic [2:0] ACT_FALLING  = 3'd1;
    localparam logic [2:0] ACT_ANY      = 3'd2;
    localparam logic [2:0] ACT_LEVEL_HI = 3'd3;
    localparam logic [2:0] ACT_LEVEL_LO = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                s1_q, s2_q;
    logic [FILTER_W-1:0] filt_cnt_q, filt_cnt_d;
    logic                hw_trig_filt_q, hw_trig_filt_d;
    logic                filt_dly_q;
    logic                trig_req_q, trig_req_d;
    logic                trig_overrun_q, trig_overrun_d;
    logic [CNT_W-1:0]    missed_cnt_q, missed_cnt_d;

    logic                trig_evt;
    logic                edge_evt;
    logic                drop;

    // Glitch filter: s2 must disagree with the filtered level for filter_len+1 cycles in a row
    always_comb begin
        filt_cnt_d     = filt_cnt_q;
        hw_trig_filt_d = hw_trig_filt_q;
        if (s2_q == hw_trig_filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q >= filter_len) begin
            hw_trig_filt_d = s2_q;
            filt_cnt_d     = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + FILTER_W'(1);
        end
    end

    // Event decode; edge_evt marks events that are dropped (and counted) while a request is pending
    always_comb begin
        trig_evt = 1'b0;
        edge_evt = 1'b0;
        case (grab_src)
            SRC_IMMEDIATE: trig_evt = 1'b1;
            SRC_SW: begin
                trig_evt = sw_trig;
                edge_evt = 1'b1;
            end
            SRC_SFNC: begin
                trig_evt = sfnc_trig;
                edge_evt = 1'b1;
            end
            SRC_HW: begin
                case (trig_act)
                    ACT_RISING: begin
                        trig_evt = hw_trig_filt_q & ~filt_dly_q;
                        edge_evt = 1'b1;
                    end
                    ACT_FALLING: begin
                        trig_evt = ~hw_trig_filt_q & filt_dly_q;
                        edge_evt = 1'b1;
                    end
                    ACT_ANY: begin
                        trig_evt = hw_trig_filt_q ^ filt_dly_q;
                        edge_evt = 1'b1;
                    end
                    ACT_LEVEL_HI: trig_evt = hw_trig_filt_q;
                    ACT_LEVEL_LO: trig_evt = ~hw_trig_filt_q;
                    default:      trig_evt = 1'b0;
                endcase
            end
            default: trig_evt = 1'b0;
        endcase
    end

    // Request FSM, overrun pulse and saturating missed counter
    always_comb begin
        state_d      = state_q;
        drop         = 1'b0;
        missed_cnt_d = missed_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grab_en && trig_evt) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!grab_en) begin
                    state_d = ST_IDLE;
                end else begin
                    drop = trig_evt & edge_evt;
                    if (trig_ack) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        trig_req_d     = (state_d == ST_REQ);
        trig_overrun_d = drop;
        if (cnt_clr) begin
            missed_cnt_d = '0;
        end else if (drop && (missed_cnt_q != {CNT_W{1'b1}})) begin
            missed_cnt_d = missed_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q        <= ST_IDLE;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            filt_cnt_q     <= '0;
            hw_trig_filt_q <= 1'b0;
            filt_dly_q     <= 1'b0;
            trig_req_q     <= 1'b0;
            trig_overrun_q <= 1'b0;
            missed_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            s1_q           <= hw_trig_in;
            s2_q           <= s1_q;
            filt_cnt_q     <= filt_cnt_d;
            hw_trig_filt_q <= hw_trig_filt_d;
            filt_dly_q     <= hw_trig_filt_q;
            trig_req_q     <= trig_req_d;
            trig_overrun_q <= trig_overrun_d;
            missed_cnt_q   <= missed_cnt_d;
        end
    end

    assign trig_req        = trig_req_q;
    assign trig_overrun    = trig_overrun_q;
    assign trig_missed_cnt = missed_cnt_q;
    assign hw_trig_filt    = hw_trig_filt_q;

endmodule

// File: tb/tb_xgs_trig_activation.sv
// Bench for xgs_trig_activation: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the trigger rules.
module tb_xgs_trig_activation;

    localparam int unsigned FW = 8;
    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, grab_en, hw, sw, sf, ack, clr;
    logic [2:0]    src, act;
    logic [FW-1:0] flen;
    logic          trig_req, trig_overrun, hw_trig_filt;
    logic [CW-1:0] missed_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    bit m_s1, m_s2, m_filt, m_dly, m_pend, m_ovr;
    int m_run, m_cnt;

    xgs_trig_activation #(.FILTER_W(FW), .CNT_W(CW)) dut (
        .sys_clk         (clk),
        .sys_reset       (rst),
        .grab_en         (grab_en),
        .grab_src        (src),
        .trig_act        (act),
        .filter_len      (flen),
        .hw_trig_in      (hw),
        .sw_trig         (sw),
        .sfnc_trig       (sf),
        .trig_ack        (ack),
        .cnt_clr         (clr),
        .trig_req        (trig_req),
        .trig_overrun    (trig_overrun),
        .trig_missed_cnt (missed_cnt),
        .hw_trig_filt    (hw_trig_filt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the intended behaviour, using the inputs present at that edge
    function automatic void model_step();
        bit ev, edge_type, drop, nf, npend;
        int nrun;
        if (rst) begin
            {m_s1, m_s2, m_filt, m_dly, m_pend, m_ovr} = '0;
            m_run = 0;
            m_cnt = 0;
            return;
        end
        ev = 1'b0;
        case (src)
            3'd1: ev = 1'b1;
            3'd3: ev = sw;
            3'd4: ev = sf;
            3'd2: case (act)
                3'd0: ev = m_filt && !m_dly;
                3'd1: ev = !m_filt && m_dly;
                3'd2: ev = m_filt != m_dly;
                3'd3: ev = m_filt;
                3'd4: ev = !m_filt;
                default: ev = 1'b0;
            endcase
            default: ev = 1'b0;
        endcase
        edge_type = (src == 3'd3) || (src == 3'd4) || (src == 3'd2 && act <= 3'd2);
        drop = m_pend && grab_en && ev && edge_type;
        nf = m_filt;
        if (m_s2 == m_filt) nrun = 0;
        else if (m_run + 1 > int'(flen)) begin
            nf   = m_s2;
            nrun = 0;
        end else nrun = m_run + 1;
        if (!grab_en)    npend = 1'b0;
        else if (m_pend) npend = !ack;
        else             npend = ev;
        if (clr)       m_cnt = 0;
        else if (drop) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        m_ovr  = drop;
        m_pend = npend;
        m_dly  = m_filt;
        m_filt = nf;
        m_run  = nrun;
        m_s2   = m_s1;
        m_s1   = hw;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("trig_req", 32'(trig_req), 32'(m_pend));
        chk("trig_overrun", 32'(trig_overrun), 32'(m_ovr));
        chk("missed_cnt", 32'(missed_cnt), 32'(m_cnt));
        chk("hw_trig_filt", 32'(hw_trig_filt), 32'(m_filt));
    endtask

    // Run n cycles acknowledging each request the cycle after it appears
    task automatic run_auto(input int n, output int req_rises, output int filt_chg);
        logic pr, pf;
        req_rises = 0;
        filt_chg  = 0;
        pr = trig_req;
        pf = hw_trig_filt;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (trig_req === 1'b1 && pr === 1'b0) req_rises++;
            if (hw_trig_filt !== pf) filt_chg++;
            pr  = trig_req;
            pf  = hw_trig_filt;
            ack = trig_req;
        end
        ack = 1'b0;
    endtask

    initial begin
        int f_at, r_at, rr, fc, rr2, fc2, n_ovr, n_same;
        logic prev;

        rst = 1'b1; grab_en = 1'b0; src = 3'd0; act = 3'd0; flen = '0;
        hw = 1'b0; sw = 1'b0; sf = 1'b0; ack = 1'b0; clr = 1'b0;
        cyc();
        cyc();
        chk("reset_req", 32'(trig_req), 32'd0);
        chk("reset_cnt", 32'(missed_cnt), 32'd0);

        // HW rising, filter_len=3, held high
        rst = 1'b0; grab_en = 1'b1; src = 3'd2; act = 3'd0; flen = 8'd3; hw = 1'b1;
        f_at = -1; r_at = -1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (hw_trig_filt === 1'b1 && f_at < 0) f_at = i;
            if (trig_req === 1'b1 && r_at < 0) r_at = i;
        end
        chk("hw_filt_latency", 32'(f_at), 32'd5);
        chk("hw_req_latency", 32'(r_at), 32'd6);
        chk("hw_req_held", 32'(trig_req), 32'd1);
        ack = 1'b1;
        cyc();
        chk("hw_req_acked", 32'(trig_req), 32'd0);
        ack = 1'b0;
        cyc();
        chk("hw_no_retrig", 32'(trig_req), 32'd0);
        hw = 1'b0;
        repeat (10) cyc();

        // Glitch rejection, filter_len=4
        flen = 8'd4;
        hw = 1'b1; run_auto(4, rr, fc);
        hw = 1'b0; run_auto(15, rr2, fc2);
        chk("glitch4_req", 32'(rr + rr2), 32'd0);
        chk("glitch4_filt", 32'(fc + fc2), 32'd0);
        hw = 1'b1; run_auto(6, rr, fc);
        hw = 1'b0; run_auto(16, rr2, fc2);
        chk("pulse6_req", 32'(rr + rr2), 32'd1);
        chk("pulse6_filt", 32'(fc + fc2), 32'd2);

        // SW trigger overruns
        src = 3'd3; clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_ovr = 0;
        for (int i = 0; i < 6; i++) begin
            sw = (i % 2 == 0);
            cyc();
            if (trig_overrun === 1'b1) n_ovr++;
        end
        chk("sw_ovr_pulses", 32'(n_ovr), 32'd2);
        chk("sw_cnt2", 32'(missed_cnt), 32'd2);
        chk("sw_req_pending", 32'(trig_req), 32'd1);
        sw = 1'b1; ack = 1'b1;
        cyc();
        chk("sw_ack_drop_cnt", 32'(missed_cnt), 32'd3);
        chk("sw_ack_req", 32'(trig_req), 32'd0);
        sw = 1'b0; ack = 1'b0;
        cyc();
        chk("sw_no_new_req", 32'(trig_req), 32'd0);

        // LEVEL_LO with immediate ack: 2-cycle period
        src = 3'd2; act = 3'd4; clr = 1'b1;
        cyc();
        clr = 1'b0;
        prev = trig_req;
        n_same = 0;
        for (int i = 0; i < 12; i++) begin
            ack = trig_req;
            cyc();
            if (trig_req === prev) n_same++;
            prev = trig_req;
        end
        chk("level_lo_toggle", 32'(n_same), 32'd0);
        chk("level_lo_cnt", 32'(missed_cnt), 32'd0);
        src = 3'd0; ack = trig_req;
        cyc();
        ack = 1'b0;
        cyc();

        // Saturation and clear-wins
        src = 3'd3; sw = 1'b1;
        repeat (21) cyc();
        chk("sat_cnt", 32'(missed_cnt), 32'(CNT_MAX));
        clr = 1'b1;
        cyc();
        chk("clr_wins_cnt", 32'(missed_cnt), 32'd0);
        chk("clr_wins_ovr", 32'(trig_overrun), 32'd1);
        clr = 1'b0;

        // grab_en abort while pending
        grab_en = 1'b0;
        cyc();
        chk("abort_req", 32'(trig_req), 32'd0);
        chk("abort_ovr", 32'(trig_overrun), 32'd0);
        sw = 1'b0; grab_en = 1'b1;
        cyc();

        // Reset during a HW level request, then full re-qualification
        src = 3'd2; act = 3'd3; flen = 8'd2; hw = 1'b1;
        for (int i = 0; i < 20 && trig_req !== 1'b1; i++) cyc();
        chk("pre_reset_req", 32'(trig_req), 32'd1);
        rst = 1'b1;
        cyc();
        chk("rst_req", 32'(trig_req), 32'd0);
        chk("rst_filt", 32'(hw_trig_filt), 32'd0);
        chk("rst_ovr", 32'(trig_overrun), 32'd0);
        chk("rst_cnt", 32'(missed_cnt), 32'd0);
        rst = 1'b0;
        r_at = -1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (trig_req === 1'b1 && r_at < 0) r_at = i;
        end
        chk("requal_latency", 32'(r_at), 32'd5);
        ack = 1'b1;
        cyc();
        ack = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) begin
                src  = 3'($urandom_range(0, 5));
                act  = 3'($urandom_range(0, 7));
                flen = FW'($urandom_range(0, 3));
            end
            grab_en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 5) == 0) hw = ~hw;
            sw  = ($urandom_range(0, 3) == 0);
            sf  = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
